// File: rtl/keypad_decimal_entry.sv
// Matrix keypad scanner with debounce that builds a three-digit decimal entry
// and emits it as a binary byte when '#' is pressed.
module keypad_decimal_entry #(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        CLK_12MHz,
  input  logic        RST_n,
  input  logic [2:0]  KEY_COL,
  output logic [3:0]  KEY_ROW,
  output logic [7:0]  VALUE,
  output logic        VALUE_VALID,
  output logic [1:0]  DIGIT_COUNT,
  output logic [11:0] ENTRY_BCD,
  output logic        OVERFLOW
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  logic [2:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic             row_tc;

  logic             hit_any, hit_multi;
  logic [3:0]       hit_key;
  logic [2:0]       col_low;
  logic [1:0]       col_pop, col_idx;
  logic [3:0]       row_key, scan_key_c, cand;
  logic             scan_any_c, scan_multi_c;

  logic [3:0]       prev_cand, stable;
  logic [DB_W-1:0]  db_cnt, db_next;
  logic             accept, armed;

  logic             press_stb;
  logic [3:0]       press_key;
  logic [9:0]       acc;

  assign row_tc  = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col_low = ~col_sync;
  assign col_pop = 2'(col_low[0]) + 2'(col_low[1]) + 2'(col_low[2]);
  assign col_idx = col_low[0] ? 2'd0 : (col_low[1] ? 2'd1 : 2'd2);

  // Key code for the single low column of the current row
  always_comb begin
    row_key = KEY_NONE;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    row_key = KEY_STAR;
        2'd1:    row_key = 4'd0;
        default: row_key = KEY_HASH;
      endcase
    end else begin
      row_key = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
    end
  end

  // Whole-scan result including the row being sampled now; multiple keys read as none
  always_comb begin
    scan_any_c   = hit_any | (col_pop != 2'd0);
    scan_multi_c = hit_multi | (col_pop > 2'd1) | (hit_any & (col_pop != 2'd0));
    scan_key_c   = hit_any ? hit_key : row_key;
    cand         = (!scan_any_c || scan_multi_c) ? KEY_NONE : scan_key_c;
    db_next      = (cand != prev_cand) ? DB_W'(1) :
                   (db_cnt == DB_W'(DEBOUNCE_SCANS)) ? db_cnt : db_cnt + DB_W'(1);
    accept       = (db_next == DB_W'(DEBOUNCE_SCANS));
  end

  // Synchronizer, row scan, debounce and press detection
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      col_meta  <= 3'b111;
      col_sync  <= 3'b111;
      div_cnt   <= '0;
      row_idx   <= 2'd0;
      KEY_ROW   <= 4'b1110;
      hit_any   <= 1'b0;
      hit_multi <= 1'b0;
      hit_key   <= KEY_NONE;
      prev_cand <= KEY_NONE;
      stable    <= KEY_NONE;
      db_cnt    <= '0;
      armed     <= 1'b0;
      press_stb <= 1'b0;
      press_key <= KEY_NONE;
    end else begin
      col_meta  <= KEY_COL;
      col_sync  <= col_meta;
      press_stb <= 1'b0;
      if (row_tc) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        KEY_ROW <= ~(4'b0001 << (row_idx + 2'd1));
        if (row_idx == 2'd3) begin
          hit_any   <= 1'b0;
          hit_multi <= 1'b0;
          hit_key   <= KEY_NONE;
          prev_cand <= cand;
          db_cnt    <= db_next;
          if (accept) begin
            stable <= cand;
            // Keys held through reset stay silent until a debounced release is seen
            if (cand == KEY_NONE) armed <= 1'b1;
            if (armed && stable == KEY_NONE && cand != KEY_NONE) begin
              press_stb <= 1'b1;
              press_key <= cand;
            end
          end
        end else begin
          hit_any   <= scan_any_c;
          hit_multi <= scan_multi_c;
          hit_key   <= scan_key_c;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Entry accumulator and byte output
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      acc         <= '0;
      VALUE       <= '0;
      VALUE_VALID <= 1'b0;
      DIGIT_COUNT <= '0;
      ENTRY_BCD   <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      VALUE_VALID <= 1'b0;
      if (press_stb) begin
        if (press_key <= 4'd9) begin
          if (DIGIT_COUNT != 2'd3) begin
            acc         <= acc * 10'd10 + {6'd0, press_key};
            ENTRY_BCD   <= {ENTRY_BCD[7:0], press_key};
            DIGIT_COUNT <= DIGIT_COUNT + 2'd1;
          end
        end else if (press_key == KEY_STAR) begin
          acc         <= '0;
          ENTRY_BCD   <= '0;
          DIGIT_COUNT <= '0;
          OVERFLOW    <= 1'b0;
        end else if (press_key == KEY_HASH && DIGIT_COUNT != 2'd0) begin
          if (acc <= 10'd255) begin
            VALUE       <= acc[7:0];
            VALUE_VALID <= 1'b1;
            OVERFLOW    <= 1'b0;
          end else begin
            OVERFLOW    <= 1'b1;
          end
          acc         <= '0;
          ENTRY_BCD   <= '0;
          DIGIT_COUNT <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Directed bench for keypad_decimal_entry: keypad short model, entry model and
// a queue of expected VALUE strobes.
module tb_keypad_decimal_entry;

  localparam int unsigned SCAN = 16;  // 4 rows x SCAN_DIV

  logic        CLK_12MHz = 1'b0;
  logic        RST_n     = 1'b0;
  logic [2:0]  KEY_COL;
  logic [3:0]  KEY_ROW;
  logic [7:0]  VALUE;
  logic        VALUE_VALID;
  logic [1:0]  DIGIT_COUNT;
  logic [11:0] ENTRY_BCD;
  logic        OVERFLOW;

  keypad_decimal_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .CLK_12MHz  (CLK_12MHz),
    .RST_n      (RST_n),
    .KEY_COL    (KEY_COL),
    .KEY_ROW    (KEY_ROW),
    .VALUE      (VALUE),
    .VALUE_VALID(VALUE_VALID),
    .DIGIT_COUNT(DIGIT_COUNT),
    .ENTRY_BCD  (ENTRY_BCD),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK_12MHz = ~CLK_12MHz;

  // Held key at position row*3+col pulls its column low while its row is driven
  logic [11:0] held = '0;
  always_comb begin
    KEY_COL = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (held[r*3+c] && !KEY_ROW[r]) KEY_COL[c] = 1'b0;
  end

  int         checks  = 0;
  int         errors  = 0;
  int         strobes = 0;
  int         pushes  = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  int         m_acc = 0;
  int         m_cnt = 0;
  logic [11:0] m_bcd = '0;
  logic [7:0] m_value = '0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keys: 0..9 digits, 10 '*', 11 '#'
  function automatic int key_pos(input int k);
    if (k >= 1 && k <= 9) return k - 1;
    if (k == 0) return 10;
    if (k == 10) return 9;
    return 11;
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_cnt < 3) begin
        m_acc = m_acc * 10 + k;
        m_bcd = {m_bcd[7:0], 4'(k)};
        m_cnt++;
      end
    end else if (k == 10) begin
      m_acc = 0; m_bcd = '0; m_cnt = 0; m_ovf = 1'b0;
    end else if (m_cnt != 0) begin
      if (m_acc <= 255) begin
        m_value = 8'(m_acc);
        m_ovf   = 1'b0;
        exp_q.push_back(m_value);
        pushes++;
      end else begin
        m_ovf = 1'b1;
      end
      m_acc = 0; m_bcd = '0; m_cnt = 0;
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge CLK_12MHz);
    @(negedge CLK_12MHz);
  endtask

  task automatic press(input int k);
    model_key(k);
    held[key_pos(k)] = 1'b1;
    wait_scans(4);
    held = '0;
    wait_scans(4);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, 32'(DIGIT_COUNT), 32'(m_cnt));
    check({tag, "_bcd"},   32'(ENTRY_BCD),   32'(m_bcd));
    check({tag, "_ovf"},   32'(OVERFLOW),    32'(m_ovf));
    check({tag, "_value"}, 32'(VALUE),       32'(m_value));
  endtask

  // Scoreboard side: every strobe must match the oldest expected byte
  always @(negedge CLK_12MHz) begin
    if (RST_n && VALUE_VALID) begin
      strobes++;
      check("strobe_single_cycle", 32'(prev_valid), 32'(0));
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed=%0h expected=none", VALUE);
      end
      if (exp_q.size() != 0) check("strobe_value", 32'(VALUE), 32'(exp_q.pop_front()));
    end
    prev_valid = VALUE_VALID;
  end

  logic [3:0] row_seq [4] = '{4'hD, 4'hB, 4'h7, 4'hE};

  initial begin
    repeat (2) @(negedge CLK_12MHz);
    check("reset_row", 32'(KEY_ROW), 32'hE);
    check_model("reset");
    check("reset_valid", 32'(VALUE_VALID), 32'(0));
    RST_n = 1'b1;
    check("row_after_release", 32'(KEY_ROW), 32'hE);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge CLK_12MHz);
      @(negedge CLK_12MHz);
      check($sformatf("row_step%0d", i), 32'(KEY_ROW), 32'(row_seq[i]));
    end
    wait_scans(3);

    // 1,2,8 then Enter
    press(1); press(2); press(8);
    check("bcd_before_enter", 32'(ENTRY_BCD), 32'h128);
    check_model("entry128");
    press(11);
    check_model("enter128");
    check("strobes_128", 32'(strobes), 32'(pushes));

    // Overflow then clear
    press(3); press(0); press(0); press(11);
    check_model("overflow300");
    check("strobes_ovf", 32'(strobes), 32'(pushes));
    press(10);
    check_model("star_clear");

    // Bouncing key 5, then long hold
    for (int i = 0; i < 5; i++) begin
      held[key_pos(5)] = (i % 2 == 0);
      wait_scans(1);
    end
    model_key(5);
    wait_scans(4);
    check_model("bounce5");
    wait_scans(20);
    check_model("hold5");
    held = '0;
    wait_scans(4);
    press(10);

    // Ghosting: 1 and 2 together
    held[key_pos(1)] = 1'b1;
    held[key_pos(2)] = 1'b1;
    wait_scans(4);
    held = '0;
    wait_scans(4);
    check_model("ghost12");

    // Fourth digit ignored
    press(9); press(9); press(9); press(1);
    check("bcd_999", 32'(ENTRY_BCD), 32'h999);
    check_model("four_digits");
    press(10);
    press(11);
    check_model("enter_empty");
    check("strobes_empty", 32'(strobes), 32'(pushes));

    // Leading zeros
    press(0); press(0); press(7);
    check_model("zeros007");
    press(11);
    check_model("enter007");

    // Reset with entry in progress and a key held
    press(4); press(2);
    model_key(7);
    held[key_pos(7)] = 1'b1;
    wait_scans(4);
    check_model("held7");
    RST_n = 1'b0;
    #1;
    m_acc = 0; m_cnt = 0; m_bcd = '0; m_value = '0; m_ovf = 1'b0;
    check("midreset_row", 32'(KEY_ROW), 32'hE);
    check_model("midreset");
    @(negedge CLK_12MHz);
    RST_n = 1'b1;
    wait_scans(6);
    check_model("held_across_reset");
    held = '0;
    wait_scans(4);
    check_model("released_after_reset");
    press(7);
    check_model("repress7");

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("strobe_total", 32'(strobes), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
